// File: rtl/regfile_2w2r_if.sv
// Register-file bus: two write ports, two combinational read ports and the
// background clear-sweep handshake. The slave modport is the register file side.
interface regfile_2w2r_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we0;
  logic [ADDR_W-1:0] waddr0;
  logic [DATA_W-1:0] wdata0;
  logic              we1;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata1;
  logic [ADDR_W-1:0] raddr0;
  logic [DATA_W-1:0] rdata0;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              clr_req;
  logic              busy;
  logic              clr_done;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr0, raddr1, clr_req,
    input  rdata0, rdata1, busy, clr_done
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr0, raddr1, clr_req,
    output rdata0, rdata1, busy, clr_done
  );
endinterface

// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file with combinational reads and a one-entry-per-cycle
// background clear sweep. Define RF_WRITE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_2w2r #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input logic           clk,
  input logic           reset,
  regfile_2w2r_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_done_q, clr_done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              busy;

  assign busy         = (state_q == CLEAR);
  assign bus.busy     = busy;
  assign bus.clr_done = clr_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-entry priority: reset, locked zero entry, sweep, port 1, port 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset || (ZERO_REG && (i == 0))) begin
        mem_q[i] <= '0;
      end else if (busy) begin
        if (cnt_q == ADDR_W'(i)) mem_q[i] <= '0;
      end else if (bus.we1 && (bus.waddr1 == ADDR_W'(i))) begin
        mem_q[i] <= bus.wdata1;
      end else if (bus.we0 && (bus.waddr0 == ADDR_W'(i))) begin
        mem_q[i] <= bus.wdata0;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;

    assign raddr = (gi == 0) ? bus.raddr0 : bus.raddr1;

    always_comb begin
      rdata = mem_q[raddr];
`ifdef RF_WRITE_BYPASS_EN
      if (bus.we1 && (bus.waddr1 == raddr)) begin
        rdata = bus.wdata1;
      end else if (bus.we0 && (bus.waddr0 == raddr)) begin
        rdata = bus.wdata0;
      end
`else
`endif
      // Sweep blanking and the hard-wired zero entry override any forwarded data.
      if (busy || (ZERO_REG && (raddr == '0))) rdata = '0;
    end
  end

  assign bus.rdata0 = g_rd[0].rdata;
  assign bus.rdata1 = g_rd[1].rdata;
endmodule

// File: doc/regfile_2w2r.md
REGFILE_2W2R -- requirements
Module: regfile_2w2r

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, bits per register entry.
REQ-002 SHALL provide parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL provide parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-004 SHALL provide ports as follows:
- clk  in  1  sole clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- we0  in  1  write enable, port 0.
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1.
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- raddr0  in  ADDR_W  read address, port 0.
- rdata0  out  DATA_W  read data, port 0, combinational.
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1, combinational.
- clr_req  in  1  start background clear sweep.
- busy  out  1  high while a clear sweep is in progress.
- clr_done  out  1  one-cycle pulse after a sweep completes.

Function
REQ-005 SHALL write wdataN to entry waddrN at posedge clk when weN=1, busy=0 and reset=0.
REQ-006 SHALL commit only wdata1 when both ports write the same address in one cycle; port 1 wins.
REQ-007 SHALL drop a write to address 0 when ZERO_REG=1; entry 0 is writable when ZERO_REG=0.
REQ-008 SHALL compute rdataN combinationally from raddrN, with zero-cycle read latency.
REQ-009 SHALL drive rdataN = 0 when ZERO_REG=1 and raddrN=0, overriding the bypass.
REQ-010 SHALL drive rdataN = 0 for every address while busy=1.
REQ-011 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-012 SHALL move IDLE->CLEAR on clr_req=1 sampled in IDLE; the sweep counter loads 0.
REQ-013 SHALL, in CLEAR, zero entry[cnt] each cycle and increment cnt, taking DEPTH cycles in total.
REQ-014 SHALL return CLEAR->IDLE after the cycle that clears entry DEPTH-1, and pulse clr_done=1 for exactly the first IDLE cycle.
REQ-015 SHALL hold busy=1 exactly while in CLEAR.
REQ-016 SHALL ignore clr_req while in CLEAR.
REQ-017 SHALL drop writes presented while busy=1; they are not queued.
REQ-018 SHALL accept a write in the same cycle clr_req is sampled in IDLE; the following sweep then zeroes it.

Reset
REQ-019 SHALL, with reset=1 at posedge clk, zero all entries in that cycle.
REQ-020 SHALL, on reset, force the FSM to IDLE, cnt=0, busy=0 and clr_done=0.
REQ-021 SHALL, on reset during CLEAR, abort the sweep without a clr_done pulse.
REQ-022 SHALL give reset priority over writes and clr_req in the same cycle.

Configuration
REQ-023 SHALL, with macro RF_WRITE_BYPASS_EN defined, drive rdataN = the same-cycle write data when weN matches raddrN and busy=0, with port 1 winning ties.
REQ-024 SHALL, with RF_WRITE_BYPASS_EN undefined, drive rdataN = stored entry contents; new data becomes visible the cycle after the write.

Verification
REQ-025 SHALL cover: reset; we0=1, waddr0=3, wdata0=0xDEADBEEF; next cycle raddr0=3 -> rdata0=0xDEADBEEF.
REQ-026 SHALL cover: we0 and we1 both to address 7 with 0x11111111 and 0x22222222 -> raddr1=7 next cycle reads 0x22222222.
REQ-027 SHALL cover: ZERO_REG=1, we0=1, waddr0=0, wdata0=0xFFFFFFFF -> raddr0=0 reads 0 in the same and next cycle.
REQ-028 SHALL cover: RF_WRITE_BYPASS_EN defined, we1=1, waddr1=5, wdata1=0xA5A5A5A5, raddr0=5 in the same cycle -> rdata0=0xA5A5A5A5; with the macro undefined -> rdata0=old value 0.
REQ-029 SHALL cover: entries 1..31 loaded, then clr_req=1 -> busy=1 for 32 cycles, a write attempted mid-sweep is dropped, clr_done pulses once, and all entries read 0.
REQ-030 SHALL cover: reset=1 at sweep cycle 10 -> busy=0 next cycle, no clr_done, all entries 0.
